uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx transmitter between NREQ byte requesters using round-robin arbitration.
//  Sits between the requester clients and the uart_tx byte interface (tx_p_data / data-valid / busy / done).
//  It captures the winning byte and holds data-valid until uart_tx reports busy.
//  It then waits for the frame to finish and re-arbitrates.
//  A timeout recovers from a transmitter that never reports busy.
// PARAMETERS
//  NREQ      4    number of requesters, 2..8
//  WIDTH     8    data width of each requester byte and of tx_p_data
//  TIMEOUT   255  max cycles in SEND waiting for busy; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk                 in   1           single clock, rising edge
//  rst                 in   1           asynchronous reset, active-high
//  req                 in   NREQ        per-requester request level; hold with data stable until gnt
//  req_data            in   NREQ*WIDTH  requester i byte at [i*WIDTH +: WIDTH]
//  gnt                 out  NREQ        one-hot, 1-cycle pulse: byte of requester i captured
//  busy                in   1           uart_tx frame in progress
//  uart_tx_done        in   1           uart_tx 1-cycle pulse at end of frame
//  tx_p_data           out  WIDTH       registered byte presented to uart_tx
//  uart_tx_data_valid  out  1           registered start request to uart_tx
//  active_id           out  $clog2(NREQ) index of requester currently being served
//  timeout_err         out  1           1-cycle pulse: SEND aborted, busy never seen
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; rr pointer=0; all outputs 0, including gnt, tx_p_data, valid, active_id and timeout_err.
//  States: IDLE -> SEND -> WAIT_DONE -> IDLE; SEND -> IDLE on timeout.
//  IDLE:
//   - Any req bit set at a rising edge selects winner w.
//   - w is the first set req bit searching from ptr upward, with wrap-around.
//   - On that edge: tx_p_data<=req_data[w]; gnt<=onehot(w) for exactly 1 cycle; active_id<=w.
//   - Also on that edge: uart_tx_data_valid<=1; cnt<=0; ptr<=(w+1)%NREQ; state->SEND.
//   - No req: stay IDLE, outputs unchanged except gnt=0.
//  SEND:
//   - valid held 1, cnt++ each cycle.
//   - busy=1 at an edge: valid<=0; state->WAIT_DONE.
//   - cnt==TIMEOUT with busy=0: valid<=0; timeout_err pulse 1 cycle; state->IDLE. ptr is already advanced, so the requester is not retried.
//   - busy and timeout on the same edge: busy wins, no error.
//  WAIT_DONE:
//   - Either uart_tx_done=1, or busy=0 seen (a falling-edge fallback), sends state->IDLE.
//   - tx_p_data stays stable for the whole frame.
//  Latency: req rises in IDLE -> gnt and valid high 1 cycle later.
//   - Minimum 1 IDLE cycle between frames, so done->next valid is 2 edges.
//  Requester rules:
//   - Drop req in the cycle gnt is seen; a req still high after gnt is served again.
//   - req changes while not in IDLE are ignored (no queuing); a requester whose req falls before grant is simply skipped.
//  Fairness: with all req high, grant order is 0,1,2,..,NREQ-1,0. No requester waits more than NREQ-1 frames.
//  uart_tx_done seen outside WAIT_DONE: ignored.
//  rst mid-frame: immediate return to reset values. The in-flight byte is abandoned; no gnt is reissued.
// STRUCTURE
//  uart_pkg:
//   - arb_state_t enum {IDLE, SEND, WAIT_DONE}, 2 bits.
//   - UART_DATA_W=8 default.
//   - function onehot(idx,n).
//  Sub-module rr_arbiter #(NREQ):
//   - Combinational.
//   - Inputs: req, ptr. Outputs: any, winner index.
//   - Search uses masked-then-unmasked priority (req & ~((1<<ptr)-1), else req).
//  Top: FSM, timeout counter, output registers, ptr register.
// TESTING
//  1 Reset: rst=1 mid-SEND -> next cycle all outputs 0 and state IDLE; after rst=0 with req=0, stays idle.
//  2 Single: req=4'b0100, data[2]=8'hA5.
//    -> gnt=4'b0100 one cycle; tx_p_data=8'hA5; valid=1 until busy=1; active_id=2.
//  3 Round-robin: req=4'b1111 held, uart_tx model busy 10 cycles then done.
//    -> gnt order 0,1,2,3,0; each byte seen once per grant.
//  4 Wrap and skip: ptr=3, req=4'b0011 -> winner 0, then winner 1; requester 3 is never granted.
//  5 Timeout: busy tied 0, TIMEOUT=255 -> valid falls and timeout_err pulses once after 256 SEND cycles.
//    -> next req is granted normally.
//  6 Stability: during WAIT_DONE toggle req and req_data.
//    -> tx_p_data unchanged; no gnt until 1 cycle after uart_tx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state type, data width default and one-hot helper
// for the uart_tx arbitration slice.
package uart_pkg;

   localparam int UART_DATA_W = 8;
   localparam int MAX_REQ     = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   function automatic logic [MAX_REQ-1:0] onehot(
      input int unsigned idx,
      input int unsigned n
   );
      logic [MAX_REQ-1:0] v;
      v = '0;
      if (idx < n && idx < MAX_REQ)
         v = MAX_REQ'(1) << idx;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req bit at or above
// ptr, wrapping to the lowest set bit when nothing is set above it.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            any,
   output logic [PW-1:0]   winner
);

   logic [NREQ-1:0] w_mask;
   logic [NREQ-1:0] w_masked;
   logic [NREQ-1:0] w_pick;

   assign w_mask   = ~((NREQ'(1) << ptr) - NREQ'(1));
   assign w_masked = req & w_mask;
   assign w_pick   = (|w_masked) ? w_masked : req;
   assign any      = |req;

   always_comb begin
      winner = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (w_pick[i])
            winner = PW'(i);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NREQ byte
// requesters, with a busy-wait timeout in SEND.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = UART_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         gnt,
   input  logic                    busy,
   input  logic                    uart_tx_done,
   output logic [WIDTH-1:0]        tx_p_data,
   output logic                    uart_tx_data_valid,
   output logic [$clog2(NREQ)-1:0] active_id,
   output logic                    timeout_err
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t      r_state;
   logic [PW-1:0]   r_ptr;
   logic [CW-1:0]   r_cnt;

   logic            w_any;
   logic [PW-1:0]   w_win;
   logic [PW-1:0]   w_ptr_nxt;
   logic [WIDTH-1:0] w_data;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req    (req),
      .ptr    (r_ptr),
      .any    (w_any),
      .winner (w_win)
   );

   always_comb begin
      w_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_win == PW'(i))
            w_data = req_data[i*WIDTH +: WIDTH];
   end

   assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state            <= IDLE;
         r_ptr              <= '0;
         r_cnt              <= '0;
         gnt                <= '0;
         tx_p_data          <= '0;
         uart_tx_data_valid <= 1'b0;
         active_id          <= '0;
         timeout_err        <= 1'b0;
      end else begin
         gnt         <= '0;
         timeout_err <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  tx_p_data          <= w_data;
                  gnt                <= NREQ'(onehot(32'(w_win), NREQ));
                  active_id          <= w_win;
                  uart_tx_data_valid <= 1'b1;
                  r_cnt              <= '0;
                  r_ptr              <= w_ptr_nxt;
                  r_state            <= SEND;
               end
            end
            SEND: begin
               // busy outranks an expiring counter on the same edge
               if (busy) begin
                  uart_tx_data_valid <= 1'b0;
                  r_state            <= WAIT_DONE;
               end else if (r_cnt == CW'(TIMEOUT)) begin
                  uart_tx_data_valid <= 1'b0;
                  timeout_err        <= 1'b1;
                  r_state            <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (uart_tx_done || !busy)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed plus randomized checks of the round-robin
// uart_tx arbiter against a transaction-level pointer/winner model.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 255;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  uart_tx_done;
   logic [WIDTH-1:0]      tx_p_data;
   logic                  uart_tx_data_valid;
   logic [1:0]            active_id;
   logic                  timeout_err;

   int total = 0;
   int bad   = 0;
   int m_ptr = 0;
   logic [WIDTH-1:0] last_byte = '0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk                (clk),
      .rst                (rst),
      .req                (req),
      .req_data           (req_data),
      .gnt                (gnt),
      .busy               (busy),
      .uart_tx_done       (uart_tx_done),
      .tx_p_data          (tx_p_data),
      .uart_tx_data_valid (uart_tx_data_valid),
      .active_id          (active_id),
      .timeout_err        (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // first requesting index at or after p, wrapping around
   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (p + k) % NREQ;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, ".gnt"},   32'(gnt), 0);
      check({tag, ".data"},  32'(tx_p_data), 0);
      check({tag, ".valid"}, 32'(uart_tx_data_valid), 0);
      check({tag, ".id"},    32'(active_id), 0);
      check({tag, ".terr"},  32'(timeout_err), 0);
   endtask

   task automatic expect_grant(input string tag, input bit drop);
      int w;
      logic [WIDTH-1:0] b;
      w = pick(req, m_ptr);
      if (w < 0) w = 0;
      b = req_data[w*WIDTH +: WIDTH];
      step();
      check({tag, ".gnt"},   32'(gnt), 32'(1) << w);
      check({tag, ".valid"}, 32'(uart_tx_data_valid), 1);
      check({tag, ".data"},  32'(tx_p_data), 32'(b));
      check({tag, ".id"},    32'(active_id), 32'(w));
      m_ptr     = (w + 1) % NREQ;
      last_byte = b;
      if (drop) req[w] = 1'b0;
      step();
      check({tag, ".gnt_pulse"}, 32'(gnt), 0);
      check({tag, ".valid_hold"}, 32'(uart_tx_data_valid), 1);
   endtask

   task automatic finish_frame(input string tag, input int pre,
                               input int blen, input bit use_done);
      repeat (pre) begin
         step();
         check({tag, ".valid_wait"}, 32'(uart_tx_data_valid), 1);
      end
      busy = 1'b1;
      step();
      check({tag, ".valid_drop"}, 32'(uart_tx_data_valid), 0);
      repeat (blen) begin
         step();
         check({tag, ".busy_gnt"}, 32'(gnt), 0);
         check({tag, ".busy_data"}, 32'(tx_p_data), 32'(last_byte));
      end
      if (use_done) begin
         uart_tx_done = 1'b1;
         step();
         uart_tx_done = 1'b0;
         busy         = 1'b0;
      end else begin
         busy = 1'b0;
         step();
      end
      check({tag, ".end_gnt"}, 32'(gnt), 0);
      check({tag, ".end_valid"}, 32'(uart_tx_data_valid), 0);
   endtask

   initial begin
      rst          = 1'b1;
      req          = '0;
      req_data     = '0;
      busy         = 1'b0;
      uart_tx_done = 1'b0;

      // reset state and idle with no requests
      #2;
      check_zero("rst0");
      step();
      rst = 1'b0;
      repeat (3) step();
      check_zero("idle");

      // reset while in SEND abandons the frame
      req      = 4'b0001;
      req_data = {$urandom};
      expect_grant("pre_rst", 1'b1);
      rst = 1'b1;
      #1;
      check_zero("rst_mid");
      step();
      rst   = 1'b0;
      m_ptr = 0;
      step();
      step();
      check_zero("post_rst");

      // single requester, done pulse in SEND is ignored
      req      = 4'b0100;
      req_data = {$urandom};
      req_data[2*WIDTH +: WIDTH] = 8'hA5;
      expect_grant("single", 1'b1);
      check("single.data_a5", 32'(tx_p_data), 32'hA5);
      check("single.id2", 32'(active_id), 2);
      uart_tx_done = 1'b1;
      step();
      uart_tx_done = 1'b0;
      check("single.done_ign", 32'(uart_tx_data_valid), 1);
      finish_frame("single", 2, 3, 1'b1);

      // wrap from ptr 3 and skip requester 3
      req = 4'b0011;
      expect_grant("wrap0", 1'b1);
      check("wrap0.id", 32'(active_id), 0);
      finish_frame("wrap0", 0, 2, 1'b1);
      expect_grant("wrap1", 1'b1);
      check("wrap1.id", 32'(active_id), 1);
      finish_frame("wrap1", 0, 2, 1'b1);

      // round-robin with all requests held from ptr 0
      rst = 1'b1;
      #1;
      rst   = 1'b0;
      m_ptr = 0;
      req_data = {$urandom};
      req      = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         expect_grant("rr", 1'b0);
         check("rr.order", 32'(active_id), 32'(k % NREQ));
         finish_frame("rr", 0, 10, 1'b1);
      end
      req = '0;

      // timeout: busy never rises
      req = 4'b1000;
      expect_grant("to", 1'b1);
      repeat (TIMEOUT - 1) begin
         step();
         check("to.valid", 32'(uart_tx_data_valid), 1);
         check("to.terr_early", 32'(timeout_err), 0);
      end
      step();
      check("to.valid_fall", 32'(uart_tx_data_valid), 0);
      check("to.terr", 32'(timeout_err), 1);
      step();
      check("to.terr_pulse", 32'(timeout_err), 0);
      req = 4'b0010;
      expect_grant("to_next", 1'b1);
      finish_frame("to_next", 1, 2, 1'b1);

      // stability while WAIT_DONE with toggling inputs
      req      = 4'b0001;
      req_data = {$urandom};
      expect_grant("stab", 1'b1);
      busy = 1'b1;
      step();
      for (int k = 0; k < 8; k++) begin
         req      = NREQ'($urandom);
         req_data = {$urandom};
         step();
         check("stab.data", 32'(tx_p_data), 32'(last_byte));
         check("stab.gnt", 32'(gnt), 0);
      end
      req          = 4'b0110;
      uart_tx_done = 1'b1;
      step();
      uart_tx_done = 1'b0;
      busy         = 1'b0;
      check("stab.done_gnt", 32'(gnt), 0);
      expect_grant("stab_next", 1'b1);
      finish_frame("stab_next", 0, 3, 1'b0);

      // randomized requests, data, busy timing and end-of-frame style
      for (int k = 0; k < 20; k++) begin
         req      = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         req_data = {$urandom};
         expect_grant("rnd", 1'b1);
         finish_frame("rnd", $urandom_range(0, 5), $urandom_range(0, 6),
                      1'($urandom_range(0, 1)));
      end
      req = '0;
      step();
      check("final.gnt", 32'(gnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
